uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Transmit scheduler for the byte-serial output path. Arbitrates between two byte
//  requesters (A = CPU port, B = monitor/debug port) with round-robin priority, frames
//  the winning byte as 8N1/8N2 (start, LSB-first data, stop) and paces the bits with an
//  internal baud divider. Sits between the CPU bus glue and the serial output pin.
// PARAMETERS
//  CLK_DIV    104  clk cycles per bit (2..65535; 104 = 115200 baud @ 12 MHz)
//  STOP_BITS  1    stop bits per frame (1 or 2)
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high reset
//  req_a_valid  in   1  requester A has a byte; held until accepted
//  req_a_data   in   8  requester A byte; stable while req_a_valid
//  req_a_ready  out  1  A byte accepted this cycle (valid && ready = handshake)
//  req_b_valid  in   1  requester B has a byte; held until accepted
//  req_b_data   in   8  requester B byte; stable while req_b_valid
//  req_b_ready  out  1  B byte accepted this cycle
//  serial_out   out  1  serial line, idle high, registered
//  tx_busy      out  1  frame in progress, registered
//  last_grant   out  1  0 = A won last arbitration, 1 = B won last
// BEHAVIOUR
//  Reset (sync, active-high): state IDLE, serial_out=1, tx_busy=0, last_grant=1
//    (A wins first tie), divider=0, bit count=0, both ready=0.
//  FSM: IDLE -> START -> DATA (8 bits) -> STOP (STOP_BITS bits) -> IDLE.
//  Arbitration (IDLE only, combinational ready): one valid -> that requester wins;
//    both valid -> requester != last_grant wins. Exactly one ready high, only in IDLE,
//    only with its valid. No ready outside IDLE.
//  Accept at cycle T: winner byte loaded into shift reg, last_grant updated, go START.
//  Line timing (registered): T+1..T+CLK_DIV serial_out=0 (start);
//    data bit i on T+1+(1+i)*CLK_DIV for CLK_DIV cycles, i=0..7, LSB first;
//    stop (=1) from T+1+9*CLK_DIV for STOP_BITS*CLK_DIV cycles.
//  tx_busy=1 from T+1 to T+(9+STOP_BITS)*CLK_DIV inclusive; IDLE re-entered at
//    T+1+(9+STOP_BITS)*CLK_DIV, earliest next accept that cycle (one extra idle-high clk).
//  Divider: counts 0..CLK_DIV-1, wraps, bit advances on wrap; cleared on accept.
//  Bit counter 0..7 in DATA, 0..STOP_BITS-1 in STOP; wraps to 0 on state change.
//  Valid deasserted before handshake: no effect, no frame. New valid during frame: waits.
//  Reset mid-frame: frame abandoned, serial_out=1 next cycle, pending valids re-arbitrated
//    from last_grant=1 after reset release.
//  Data sampled only at handshake; later changes on req_x_data ignored.
// STRUCTURE
//  uart_pkg: state enum (S_IDLE,S_START,S_DATA,S_STOP), DATA_BITS=8, frame-length
//    function (1+DATA_BITS+STOP_BITS).
//  Sub-module uart_baud_div: CLK_DIV counter with clear input and one-cycle tick output.
//  Arbiter, FSM, shift register and output flops stay in uart_tx_sched.
// TESTING (CLK_DIV=4 unless noted)
//  1 Reset: hold reset 3 clk -> serial_out=1, tx_busy=0, readys=0, last_grant=1.
//  2 A only, 0xA5 at T -> req_a_ready=1 at T; line 0,1,0,1,0,0,1,0,1,1 each 4 clk from
//    T+1; tx_busy high 40 clk; last_grant=0.
//  3 A=0x00 and B=0xFF valid together -> A accepted first, B accepted on IDLE cycle at
//    T+41; B frame = 0, eight 1s, 1; last_grant=1.
//  4 B held valid 3 frames, A joins mid-frame 1 -> grants B, A, B.
//  5 STOP_BITS=2, 0x3C -> stop high 8 clk, tx_busy 44 clk, next accept at T+45.
//  6 Reset asserted at T+15 of frame -> serial_out=1 next clk, tx_busy=0, held valid
//    re-accepted after release; CLK_DIV=104 run: bit period exactly 104 clk.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam int unsigned DATA_BITS = 8;

  // Line bits per frame: start + data + stop.
  function automatic int unsigned frame_bits(input int unsigned stop_bits);
    return 1 + DATA_BITS + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Two byte requesters (A = CPU, B = monitor) feeding the transmit scheduler.
interface uart_tx_sched_if;
  import uart_pkg::*;

  logic                 req_a_valid;
  logic [DATA_BITS-1:0] req_a_data;
  logic                 req_a_ready;
  logic                 req_b_valid;
  logic [DATA_BITS-1:0] req_b_data;
  logic                 req_b_ready;

  modport master (
    output req_a_valid, req_a_data, req_b_valid, req_b_data,
    input  req_a_ready, req_b_ready
  );

  modport slave (
    input  req_a_valid, req_a_data, req_b_valid, req_b_data,
    output req_a_ready, req_b_ready
  );

endinterface

// File: rtl/uart_baud_div.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled, one-cycle tick on wrap.
module uart_baud_div #(
  parameter int unsigned CLK_DIV = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick_c
);

  localparam int unsigned     CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick_c = enable && (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick_c) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter between two byte requesters driving one 8N1/8N2 serial line.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 104,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_sched_if.slave   req,
  output logic             serial_out,
  output logic             tx_busy,
  output logic             last_grant
);

  localparam int unsigned      BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 serial_nxt;
  logic                 grant_nxt;
  logic                 div_clr_c;
  logic                 div_en_c;
  logic                 tick_c;
  logic                 ready_a_c;
  logic                 ready_b_c;

  assign div_en_c        = (state != S_IDLE);
  assign req.req_a_ready = ready_a_c;
  assign req.req_b_ready = ready_b_c;

  uart_baud_div #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (div_clr_c),
    .enable (div_en_c),
    .tick_c (tick_c)
  );

  // Next state, arbitration and the next value of every output flop.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    serial_nxt  = serial_out;
    grant_nxt   = last_grant;
    div_clr_c   = 1'b0;
    ready_a_c   = 1'b0;
    ready_b_c   = 1'b0;

    unique case (state)
      S_IDLE: begin
        serial_nxt = 1'b1;
        if (!reset && (req.req_a_valid || req.req_b_valid)) begin
          // On a tie the requester that did not win last time gets the line.
          if (req.req_a_valid && (!req.req_b_valid || last_grant)) begin
            ready_a_c = 1'b1;
            grant_nxt = 1'b0;
            shift_nxt = req.req_a_data;
          end else begin
            ready_b_c = 1'b1;
            grant_nxt = 1'b1;
            shift_nxt = req.req_b_data;
          end
          state_nxt   = S_START;
          serial_nxt  = 1'b0;
          bit_cnt_nxt = '0;
          div_clr_c   = 1'b1;
        end
      end

      S_START: begin
        if (tick_c) begin
          state_nxt  = S_DATA;
          serial_nxt = shift[0];
        end
      end

      S_DATA: begin
        if (tick_c) begin
          if (bit_cnt == DATA_LAST) begin
            state_nxt   = S_STOP;
            serial_nxt  = 1'b1;
            bit_cnt_nxt = '0;
          end else begin
            shift_nxt   = shift >> 1;
            serial_nxt  = shift[1];
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end

      S_STOP: begin
        if (tick_c) begin
          if (bit_cnt == STOP_LAST) begin
            state_nxt   = S_IDLE;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      serial_out <= serial_nxt;
      tx_busy    <= (state_nxt != S_IDLE);
      last_grant <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: three configurations checked every cycle against a frame-timing model.
module tb_uart_tx_sched;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst [N];
  logic       av  [N];
  logic [7:0] ad  [N];
  logic       bv  [N];
  logic [7:0] bd  [N];
  logic       ar  [N];
  logic       br  [N];
  logic       so  [N];
  logic       busy[N];
  logic       lg  [N];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model configuration and state: instance 0 = 4/1, 1 = 4/2, 2 = 104/1.
  int         mdiv  [N] = '{4, 4, 104};
  int         mstop [N] = '{1, 2, 1};
  logic       fr    [N] = '{1'b0, 1'b0, 1'b0};
  int         t0    [N] = '{0, 0, 0};
  logic [7:0] mbyte [N] = '{8'h00, 8'h00, 8'h00};
  logic       mlast [N] = '{1'b1, 1'b1, 1'b1};
  logic       mvalid[N] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_sched_if ifc ();

    uart_tx_sched #(
      .CLK_DIV   ((g == 2) ? 104 : 4),
      .STOP_BITS ((g == 1) ? 2 : 1)
    ) dut (
      .clk        (clk),
      .reset      (rst[g]),
      .req        (ifc),
      .serial_out (so[g]),
      .tx_busy    (busy[g]),
      .last_grant (lg[g])
    );

    assign ifc.req_a_valid = av[g];
    assign ifc.req_a_data  = ad[g];
    assign ifc.req_b_valid = bv[g];
    assign ifc.req_b_data  = bd[g];
    assign ar[g]           = ifc.req_a_ready;
    assign br[g]           = ifc.req_b_ready;
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at cycle %0d", name, idx, act, exp, cyc);
    end
  endtask

  // Expected outputs follow from the accept cycle of the current frame and the byte taken.
  task automatic model_step(input int i);
    int   f;
    int   rel;
    int   k;
    logic idle;
    logic e_so;
    logic e_ar;
    logic e_br;
    f    = (9 + mstop[i]) * mdiv[i];
    rel  = cyc - t0[i];
    idle = !(fr[i] && rel >= 1 && rel <= f);
    e_so = 1'b1;
    if (!idle) begin
      k = (rel - 1) / mdiv[i];
      if (k == 0)      e_so = 1'b0;
      else if (k <= 8) e_so = mbyte[i][k-1];
    end
    e_ar = 1'b0;
    e_br = 1'b0;
    if (idle && !rst[i]) begin
      if (av[i] && (!bv[i] || mlast[i])) e_ar = 1'b1;
      else if (bv[i])                     e_br = 1'b1;
    end
    if (mvalid[i]) begin
      chk("model serial_out", i, 32'(so[i]), 32'(e_so));
      chk("model tx_busy", i, 32'(busy[i]), 32'(!idle));
      chk("model last_grant", i, 32'(lg[i]), 32'(mlast[i]));
      chk("model req_a_ready", i, 32'(ar[i]), 32'(e_ar));
      chk("model req_b_ready", i, 32'(br[i]), 32'(e_br));
    end
    if (rst[i]) begin
      fr[i]     = 1'b0;
      mlast[i]  = 1'b1;
      mvalid[i] = 1'b1;
    end else if (e_ar || e_br) begin
      fr[i]    = 1'b1;
      t0[i]    = cyc;
      mbyte[i] = e_ar ? ad[i] : bd[i];
      mlast[i] = e_br;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) model_step(i);
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts on the cycle after accept; pat holds the expected line level per bit slot.
  task automatic check_frame(input int i, input int d, input int slots, input logic [11:0] pat);
    for (int j = 0; j < slots * d; j++) begin
      @(negedge clk);
      chk("frame serial_out", i, 32'(so[i]), 32'(pat[j / d]));
      chk("frame tx_busy", i, 32'(busy[i]), 32'd1);
    end
    @(negedge clk);
    chk("frame end tx_busy", i, 32'(busy[i]), 32'd0);
    chk("frame end serial_out", i, 32'(so[i]), 32'd1);
  endtask

  task automatic wait_grant(input int i, output int who);
    who = -1;
    for (int n = 0; n < 200 && who < 0; n++) begin
      @(negedge clk);
      if (ar[i] === 1'b1)      who = 0;
      else if (br[i] === 1'b1) who = 1;
    end
  endtask

  task automatic wait_idle(input int i, input int bound);
    int n;
    n = 0;
    while (busy[i] !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait idle", i, 32'(busy[i]), 32'd0);
  endtask

  task automatic count_run(input int i, input logic lvl, output int n);
    n = 0;
    while (so[i] === lvl && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   who;
    int   n;
    logic hsa[N];
    logic hsb[N];

    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; av[i] = 1'b0; bv[i] = 1'b0; ad[i] = 8'h00; bd[i] = 8'h00;
    end

    // Reset held three clocks.
    repeat (3) next_cycle();
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("reset serial_out", i, 32'(so[i]), 32'd1);
      chk("reset tx_busy", i, 32'(busy[i]), 32'd0);
      chk("reset last_grant", i, 32'(lg[i]), 32'd1);
      chk("reset ready_a", i, 32'(ar[i]), 32'd0);
      chk("reset ready_b", i, 32'(br[i]), 32'd0);
    end

    // A alone sends 0xA5.
    next_cycle();
    av[0] = 1'b1; ad[0] = 8'hA5;
    @(negedge clk);
    chk("a5 ready_a", 0, 32'(ar[0]), 32'd1);
    next_cycle();
    av[0] = 1'b0; ad[0] = 8'h00;
    check_frame(0, 4, 10, 12'h34A);
    chk("a5 last_grant", 0, 32'(lg[0]), 32'd0);

    // Tie after reset: A first, B on the idle cycle at T+41.
    next_cycle();
    rst[0] = 1'b1;
    next_cycle();
    rst[0] = 1'b0;
    av[0] = 1'b1; ad[0] = 8'h00; bv[0] = 1'b1; bd[0] = 8'hFF;
    @(negedge clk);
    chk("tie ready_a", 0, 32'(ar[0]), 32'd1);
    chk("tie ready_b", 0, 32'(br[0]), 32'd0);
    next_cycle();
    av[0] = 1'b0;
    check_frame(0, 4, 10, 12'h200);
    chk("tie b at T+41", 0, 32'(br[0]), 32'd1);
    next_cycle();
    bv[0] = 1'b0;
    check_frame(0, 4, 10, 12'h3FE);
    chk("tie last_grant", 0, 32'(lg[0]), 32'd1);

    // B held for three frames, A joins during the first: B, A, B.
    next_cycle();
    rst[0] = 1'b1;
    next_cycle();
    rst[0] = 1'b0;
    bv[0] = 1'b1; bd[0] = 8'h11;
    wait_grant(0, who);
    chk("rr grant 1", 0, 32'(who), 32'd1);
    next_cycle();
    bd[0] = 8'h22;
    repeat (10) @(posedge clk);
    #1;
    av[0] = 1'b1; ad[0] = 8'h33;
    wait_grant(0, who);
    chk("rr grant 2", 0, 32'(who), 32'd0);
    next_cycle();
    av[0] = 1'b0;
    wait_grant(0, who);
    chk("rr grant 3", 0, 32'(who), 32'd1);
    next_cycle();
    bv[0] = 1'b0;
    wait_idle(0, 200);

    // Two stop bits: 0x3C, 44 busy clocks, next accept at T+45.
    next_cycle();
    av[1] = 1'b1; ad[1] = 8'h3C;
    @(negedge clk);
    chk("stop2 ready_a", 1, 32'(ar[1]), 32'd1);
    next_cycle();
    av[1] = 1'b0; bv[1] = 1'b1; bd[1] = 8'h77;
    check_frame(1, 4, 11, 12'h678);
    chk("stop2 accept T+45", 1, 32'(br[1]), 32'd1);
    next_cycle();
    bv[1] = 1'b0;

    // Reset in the middle of a frame with A still requesting.
    next_cycle();
    av[0] = 1'b1; ad[0] = 8'h5A;
    @(negedge clk);
    chk("midrst ready_a", 0, 32'(ar[0]), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    next_cycle();
    rst[0] = 1'b0;
    @(negedge clk);
    chk("midrst serial_out", 0, 32'(so[0]), 32'd1);
    chk("midrst tx_busy", 0, 32'(busy[0]), 32'd0);
    chk("midrst last_grant", 0, 32'(lg[0]), 32'd1);
    chk("midrst reaccept", 0, 32'(ar[0]), 32'd1);
    next_cycle();
    av[0] = 1'b0;
    wait_idle(0, 200);

    // Full-rate divider: every bit lasts 104 clocks.
    next_cycle();
    av[2] = 1'b1; ad[2] = 8'h55;
    @(negedge clk);
    chk("div104 ready_a", 2, 32'(ar[2]), 32'd1);
    next_cycle();
    av[2] = 1'b0;
    @(negedge clk);
    count_run(2, 1'b0, n);
    chk("div104 start len", 2, 32'(n), 32'd104);
    count_run(2, 1'b1, n);
    chk("div104 bit0 len", 2, 32'(n), 32'd104);
    count_run(2, 1'b0, n);
    chk("div104 bit1 len", 2, 32'(n), 32'd104);
    wait_idle(2, 2000);

    // Random traffic, withdrawals and resets on all three instances.
    repeat (6000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        hsa[i] = av[i] && (ar[i] === 1'b1);
        hsb[i] = bv[i] && (br[i] === 1'b1);
      end
      next_cycle();
      for (int i = 0; i < N; i++) begin
        rst[i] = ($urandom_range(0, 100 * mdiv[i] - 1) == 0);
        if (hsa[i]) begin
          av[i] = 1'($urandom_range(0, 1)); ad[i] = 8'($urandom);
        end else if (!av[i]) begin
          ad[i] = 8'($urandom);
          av[i] = ($urandom_range(0, 3) == 0);
        end else if ($urandom_range(0, 31) == 0) begin
          av[i] = 1'b0;
        end
        if (hsb[i]) begin
          bv[i] = 1'($urandom_range(0, 1)); bd[i] = 8'($urandom);
        end else if (!bv[i]) begin
          bd[i] = 8'($urandom);
          bv[i] = ($urandom_range(0, 3) == 0);
        end else if ($urandom_range(0, 31) == 0) begin
          bv[i] = 1'b0;
        end
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
